// File: rtl/vldrdy_pkg.sv
// Shared types and helpers for the valid/ready arbitration fabric.
package vldrdy_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STALL = 2'd1,
      S_PKT   = 2'd2
   } arb_state_t;

   // Index width with a floor of one bit so N=1 style corners still elaborate.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vldrdy_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module vldrdy_rr_pick
   import vldrdy_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   localparam logic [IW:0] N_W = (IW+1)'(N);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] rot;
   logic [IW-1:0]  off;
   logic [IW:0]    sum;
   logic [IW:0]    wrapped;

   // After the shift, rot[j] holds req[(ptr + j) mod N] for j < N.
   assign dbl = {req, req};
   assign rot = dbl >> ptr;

   always_comb begin
      off = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (rot[j]) off = IW'(j);
      end
      any     = |req;
      sum     = {1'b0, ptr} + {1'b0, off};
      wrapped = sum - N_W;
      idx     = (sum >= N_W) ? wrapped[IW-1:0] : sum[IW-1:0];
   end

endmodule

// File: rtl/vldrdy_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with zero-latency data path and
// grant hold across downstream stalls and (optionally) whole packets.
module vldrdy_rr_arbiter
   import vldrdy_pkg::*;
#(
   parameter int N        = 4,
   parameter int DW       = 32,
   parameter bit PKT_MODE = 1'b1,
   parameter int IW       = idx_w(N)
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic [N-1:0]    up_valid,
   output logic [N-1:0]    up_ready,
   input  logic [N*DW-1:0] up_data,
   input  logic [N-1:0]    up_last,
   output logic            dn_valid,
   input  logic            dn_ready,
   output logic [DW-1:0]   dn_data,
   output logic            dn_last,
   output logic [IW-1:0]   dn_id
);

   arb_state_t    st_q, st_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] lock_q, lock_d;

   logic          pick_any;
   logic [IW-1:0] pick_idx;
   logic [IW-1:0] grant;
   logic          fire;
   logic          done;
   logic [DW-1:0] data_arr [N];

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (i == IW'(N - 1)) ? '0 : i + IW'(1);
   endfunction

   vldrdy_rr_pick #(.N(N), .IW(IW)) u_pick (
      .req (up_valid),
      .ptr (ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign grant    = (st_q == S_IDLE) ? pick_idx : lock_q;
   assign dn_valid = (st_q == S_IDLE) ? pick_any : up_valid[lock_q];
   assign dn_id    = grant;
   assign dn_data  = data_arr[grant];
   assign dn_last  = PKT_MODE ? up_last[grant] : 1'b1;
   assign fire     = dn_valid && dn_ready;
   // dn_last is forced high without packet mode, so every fire completes.
   assign done     = fire && dn_last;

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign data_arr[gi] = up_data[gi*DW +: DW];
      assign up_ready[gi] = fire && (grant == IW'(gi));
   end

   always_comb begin
      st_d   = st_q;
      ptr_d  = ptr_q;
      lock_d = lock_q;
      case (st_q)
         S_IDLE: begin
            if (done) begin
               ptr_d = wrap_inc(grant);
            end else if (dn_valid) begin
               lock_d = grant;
               st_d   = fire ? S_PKT : S_STALL;
            end
         end
         S_STALL: begin
            // A requester withdrawing valid mid-stall frees the channel without
            // charging it a turn.
            if (!up_valid[lock_q]) begin
               st_d = S_IDLE;
            end else if (done) begin
               st_d  = S_IDLE;
               ptr_d = wrap_inc(lock_q);
            end else if (fire) begin
               st_d = S_PKT;
            end
         end
         S_PKT: begin
            if (done) begin
               st_d  = S_IDLE;
               ptr_d = wrap_inc(lock_q);
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         st_q   <= S_IDLE;
         ptr_q  <= '0;
         lock_q <= '0;
      end else begin
         st_q   <= st_d;
         ptr_q  <= ptr_d;
         lock_q <= lock_d;
      end
   end

`ifndef SYNTHESIS
   a_stall_hold: assert property (@(posedge clock) disable iff (!resetn)
      (st_q == S_STALL) |-> up_valid[lock_q]);
   a_data_stable: assert property (@(posedge clock) disable iff (!resetn)
      (dn_valid && !dn_ready) |=> $stable(dn_data));
`endif

endmodule

// File: tb/tb_vldrdy_rr_arbiter.sv
// Bench for vldrdy_rr_arbiter: directed scenarios plus randomized traffic on
// three instances (N=4 beat mode, N=4 packet mode, N=3 beat mode).
module tb_vldrdy_rr_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        resetn;
   logic [3:0]  v_i [3];
   logic [3:0]  l_i [3];
   logic        dr_i [3];
   logic [31:0] d_i [3][4];

   logic [3:0]  o_rdy [3];
   logic [2:0]  rdy2;
   logic        o_v [3];
   logic        o_l [3];
   logic [31:0] o_d [3];
   logic [1:0]  o_id [3];

   assign o_rdy[2] = {1'b0, rdy2};

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: owner = requester currently holding the channel (-1 = free)
   int m_ptr [3];
   int m_own [3];

   vldrdy_rr_arbiter #(.N(4), .DW(32), .PKT_MODE(1'b0)) dut0 (
      .clock(clock), .resetn(resetn),
      .up_valid(v_i[0]), .up_ready(o_rdy[0]),
      .up_data({d_i[0][3], d_i[0][2], d_i[0][1], d_i[0][0]}), .up_last(l_i[0]),
      .dn_valid(o_v[0]), .dn_ready(dr_i[0]), .dn_data(o_d[0]),
      .dn_last(o_l[0]), .dn_id(o_id[0])
   );

   vldrdy_rr_arbiter #(.N(4), .DW(32), .PKT_MODE(1'b1)) dut1 (
      .clock(clock), .resetn(resetn),
      .up_valid(v_i[1]), .up_ready(o_rdy[1]),
      .up_data({d_i[1][3], d_i[1][2], d_i[1][1], d_i[1][0]}), .up_last(l_i[1]),
      .dn_valid(o_v[1]), .dn_ready(dr_i[1]), .dn_data(o_d[1]),
      .dn_last(o_l[1]), .dn_id(o_id[1])
   );

   vldrdy_rr_arbiter #(.N(3), .DW(32), .PKT_MODE(1'b0)) dut2 (
      .clock(clock), .resetn(resetn),
      .up_valid(v_i[2][2:0]), .up_ready(rdy2),
      .up_data({d_i[2][2], d_i[2][1], d_i[2][0]}), .up_last(l_i[2][2:0]),
      .dn_valid(o_v[2]), .dn_ready(dr_i[2]), .dn_data(o_d[2]),
      .dn_last(o_l[2]), .dn_id(o_id[2])
   );

   function automatic int n_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction

   // Expected grant: owner if the channel is held, else first valid scanning from ptr.
   function automatic void expect_out(input int k, output int g, output bit v);
      v = 1'b0;
      g = 0;
      if (m_own[k] >= 0) begin
         g = m_own[k];
         v = v_i[k][g];
      end else begin
         for (int j = 0; j < n_of(k); j++) begin
            int c;
            c = (m_ptr[k] + j) % n_of(k);
            if (!v && v_i[k][c]) begin
               g = c;
               v = 1'b1;
            end
         end
      end
   endfunction

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int g;
         bit v, fire, last;
         expect_out(k, g, v);
         fire = v && dr_i[k];
         last = (k == 1) ? l_i[k][g] : 1'b1;
         if (m_own[k] < 0) begin
            if (fire && last) m_ptr[k] = (g + 1) % n_of(k);
            else if (v) m_own[k] = g;
         end else if (fire && last) begin
            m_ptr[k] = (m_own[k] + 1) % n_of(k);
            m_own[k] = -1;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 3; k++) begin
         v_i[k]  = '0;
         l_i[k]  = '0;
         dr_i[k] = 1'b0;
         for (int i = 0; i < 4; i++) d_i[k][i] = $urandom;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         m_ptr[k] = 0;
         m_own[k] = -1;
      end
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      clear_inputs();
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (o_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_dn_valid dut=%0d got=%b want=0", k, o_v[k]);
         end
         n_cmp++;
         if (o_rdy[k] !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_up_ready dut=%0d got=%b want=0000", k, o_rdy[k]);
         end
      end
      v_i[0] = 4'b1111;
      @(negedge clock);
      n_cmp++;
      if (o_v[0] !== 1'b1 || o_id[0] !== 2'd0) begin
         n_err++;
         $display("FAIL reset_ptr valid=%b id=%0d want valid=1 id=0", o_v[0], o_id[0]);
      end
      do_reset();
      $display("test_reset done");
   endtask

   task automatic test_round_robin();
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      do_reset();
      v_i[0]  = 4'b1111;
      dr_i[0] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         n_cmp++;
         if (o_id[0] !== 2'(exp_seq[c])) begin
            n_err++;
            $display("FAIL rr_id cyc=%0d got=%0d want=%0d", c, o_id[0], exp_seq[c]);
         end
         n_cmp++;
         if (o_rdy[0] !== (4'b0001 << exp_seq[c])) begin
            n_err++;
            $display("FAIL rr_ready cyc=%0d got=%b want=%b", c, o_rdy[0], 4'b0001 << exp_seq[c]);
         end
         tick();
      end
      $display("test_round_robin done");
   endtask

   task automatic test_stall();
      do_reset();
      v_i[0] = 4'b1010;
      for (int c = 0; c < 4; c++) begin
         dr_i[0] = (c == 3);
         @(negedge clock);
         n_cmp++;
         if (o_id[0] !== 2'd1 || o_d[0] !== d_i[0][1] || o_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL stall_hold cyc=%0d got id=%0d data=%h want id=1 data=%h", c, o_id[0], o_d[0], d_i[0][1]);
         end
         n_cmp++;
         if (o_rdy[0] !== ((c == 3) ? 4'b0010 : 4'b0000)) begin
            n_err++;
            $display("FAIL stall_ready cyc=%0d got=%b", c, o_rdy[0]);
         end
         tick();
      end
      @(negedge clock);
      n_cmp++;
      if (o_id[0] !== 2'd3 || o_rdy[0] !== 4'b1000) begin
         n_err++;
         $display("FAIL stall_next got id=%0d ready=%b want id=3 ready=1000", o_id[0], o_rdy[0]);
      end
      tick();
      $display("test_stall done");
   endtask

   task automatic test_packet();
      // cycle 0 serves requester 1 so the pointer moves to 2 before the packet
      logic [3:0] t_v   [6] = '{4'b0010, 4'b0101, 4'b0001, 4'b0101, 4'b0101, 4'b0001};
      logic [3:0] t_l   [6] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0101, 4'b0001};
      logic       t_ev  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      int         t_id  [6] = '{1, 2, 2, 2, 2, 0};
      do_reset();
      dr_i[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         v_i[1] = t_v[c];
         l_i[1] = t_l[c];
         d_i[1][2] = $urandom;
         @(negedge clock);
         n_cmp++;
         if (o_v[1] !== t_ev[c]) begin
            n_err++;
            $display("FAIL pkt_valid cyc=%0d got=%b want=%b", c, o_v[1], t_ev[c]);
         end
         n_cmp++;
         if (o_rdy[1] !== (t_ev[c] ? (4'b0001 << t_id[c]) : 4'b0000)) begin
            n_err++;
            $display("FAIL pkt_ready cyc=%0d got=%b", c, o_rdy[1]);
         end
         if (t_ev[c]) begin
            n_cmp++;
            if (o_id[1] !== 2'(t_id[c]) || o_d[1] !== d_i[1][t_id[c]] || o_l[1] !== t_l[c][t_id[c]]) begin
               n_err++;
               $display("FAIL pkt_beat cyc=%0d got id=%0d data=%h last=%b want id=%0d", c, o_id[1], o_d[1], o_l[1], t_id[c]);
            end
         end
         tick();
      end
      $display("test_packet done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      v_i[1]  = 4'b1000;
      l_i[1]  = 4'b1000;
      dr_i[1] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         d_i[1][3] = $urandom;
         @(negedge clock);
         n_cmp++;
         if (o_id[1] !== 2'd3 || o_rdy[1] !== 4'b1000 || o_d[1] !== d_i[1][3]) begin
            n_err++;
            $display("FAIL b2b cyc=%0d got id=%0d ready=%b data=%h want id=3 ready=1000 data=%h", c, o_id[1], o_rdy[1], o_d[1], d_i[1][3]);
         end
         tick();
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_mid_packet();
      do_reset();
      v_i[1]  = 4'b0010;
      dr_i[1] = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         n_cmp++;
         if (o_id[1] !== 2'd1 || o_rdy[1] !== 4'b0010) begin
            n_err++;
            $display("FAIL midpkt_beat cyc=%0d got id=%0d ready=%b want id=1", c, o_id[1], o_rdy[1]);
         end
         if (c == 0) tick();
      end
      resetn = 1'b0;
      @(posedge clock);
      #1;
      clear_inputs();
      @(posedge clock);
      #1;
      resetn = 1'b1;
      v_i[1] = 4'b1111;
      l_i[1] = 4'b0000;
      @(negedge clock);
      n_cmp++;
      if (o_id[1] !== 2'd0 || o_v[1] !== 1'b1 || o_rdy[1] !== 4'b0000) begin
         n_err++;
         $display("FAIL midpkt_after got id=%0d valid=%b ready=%b want id=0 valid=1 ready=0000", o_id[1], o_v[1], o_rdy[1]);
      end
      @(posedge clock);
      #1;
      dr_i[1] = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (o_id[1] !== 2'd0 || o_rdy[1] !== 4'b0001) begin
         n_err++;
         $display("FAIL midpkt_release got id=%0d ready=%b want id=0 ready=0001", o_id[1], o_rdy[1]);
      end
      @(posedge clock);
      #1;
      $display("test_reset_mid_packet done");
   endtask

   task automatic test_n3();
      do_reset();
      v_i[2]  = 4'b0111;
      dr_i[2] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         n_cmp++;
         if (o_id[2] !== 2'(c % 3) || o_rdy[2] !== (4'b0001 << (c % 3))) begin
            n_err++;
            $display("FAIL n3_seq cyc=%0d got id=%0d ready=%b want id=%0d", c, o_id[2], o_rdy[2], c % 3);
         end
         tick();
      end
      $display("test_n3 done");
   endtask

   task automatic test_random();
      int acc [3];
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < n_of(k); i++) begin
               if (!v_i[k][i] && $urandom_range(0, 2) == 0) begin
                  v_i[k][i] = 1'b1;
                  d_i[k][i] = $urandom;
                  l_i[k][i] = (k == 1) ? ($urandom_range(0, 2) == 0) : 1'($urandom);
               end
            end
            dr_i[k] = ($urandom_range(0, 3) != 0);
         end
         @(negedge clock);
         for (int k = 0; k < 3; k++) begin
            int g;
            bit v;
            expect_out(k, g, v);
            acc[k] = (v && dr_i[k]) ? g : -1;
            n_cmp++;
            if (o_v[k] !== v) begin
               n_err++;
               $display("FAIL rand_valid dut=%0d cyc=%0d got=%b want=%b", k, cyc, o_v[k], v);
            end
            n_cmp++;
            if (o_rdy[k] !== ((v && dr_i[k]) ? (4'b0001 << g) : 4'b0000)) begin
               n_err++;
               $display("FAIL rand_ready dut=%0d cyc=%0d got=%b grant=%0d", k, cyc, o_rdy[k], g);
            end
            if (v) begin
               n_cmp++;
               if (o_id[k] !== 2'(g) || o_d[k] !== d_i[k][g] || o_l[k] !== ((k == 1) ? l_i[k][g] : 1'b1)) begin
                  n_err++;
                  $display("FAIL rand_out dut=%0d cyc=%0d got id=%0d data=%h last=%b want id=%0d data=%h", k, cyc, o_id[k], o_d[k], o_l[k], g, d_i[k][g]);
               end
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            if (acc[k] >= 0) v_i[k][acc[k]] = 1'b0;
         end
      end
      $display("test_random done");
   endtask

   initial begin
      resetn = 1'b0;
      clear_inputs();
      test_reset();
      test_round_robin();
      test_stall();
      test_packet();
      test_back_to_back();
      test_reset_mid_packet();
      test_n3();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
